// File: rtl/pie_frame_encoder.sv
// pie_frame_encoder
// Reader-to-tag PIE modulator with run-time timing. A frame is a delimiter,
// a data-0 symbol, RTcal, an optional TRcal (preamble) and then the data bits
// pulled from a valid/ready stream until the bit flagged last has been sent.
// Every symbol segment is high-then-low: high while the down-counter is at or
// above PW, low for its final PW cycles.
//
// Optional feature macro: PIE_UNDERRUN_ABORT_EN
//   defined   : a data underrun aborts the frame (back to IDLE, carrier on)
//   undefined : a data underrun parks in WAIT with the carrier on until the
//               next bit arrives, stretching that symbol's high time
module pie_frame_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cfg_pw,
  input  logic [CNT_W-1:0] cfg_zero,
  input  logic [CNT_W-1:0] cfg_one,
  input  logic [CNT_W-1:0] cfg_delim,
  input  logic [CNT_W-1:0] cfg_rtcal,
  input  logic [CNT_W-1:0] cfg_trcal,
  input  logic             cfg_preamble,
  input  logic             in_valid,
  output logic             in_rdy,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_pie,
  output logic             busy,
  output logic             cfg_err,
  output logic             underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELIM,
    S_DATA0,
    S_RTCAL,
    S_TRCAL,
    S_DATA,
    S_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Frame state and registered outputs
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_pie;
  logic             r_busy;
  logic             r_cfg_err;
  logic             r_underrun;

  // Timing shadow copies, frozen for the whole frame
  logic [CNT_W-1:0] r_pw;
  logic [CNT_W-1:0] r_zero;
  logic [CNT_W-1:0] r_one;
  logic [CNT_W-1:0] r_rtcal;
  logic [CNT_W-1:0] r_trcal;
  logic             r_pre;
  logic             r_last;

  // Next-state values
  state_t           w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_last_nx;
  logic             w_load_cfg;
  logic             w_cfg_err_nx;
  logic             w_underrun_nx;
  logic             w_out_pie_nx;
  logic [CNT_W-1:0] w_pw_nx;

  logic             w_cfg_ok;
  logic             w_cnt_zero;
  logic             w_rdy;
  logic [CNT_W-1:0] w_bit_cnt;

  // The frame may only start if the timing is self-consistent
  assign w_cfg_ok = (cfg_pw != '0) &&
                    (cfg_pw < cfg_zero) &&
                    (cfg_zero <= cfg_one) &&
                    (cfg_one <= cfg_rtcal) &&
                    (cfg_rtcal <= cfg_trcal) &&
                    (cfg_delim != '0);

  assign w_cnt_zero = (r_cnt == '0);

  // Counter load value for the symbol carrying the offered bit
  assign w_bit_cnt = (in_bit ? r_one : r_zero) - CNT_ONE;

  // Ready is decoded from state/counter: asserted on the last cycle of the
  // segment that precedes a data symbol, or continuously while waiting
  always_comb begin
    w_rdy = 1'b0;
    case (r_state)
      S_RTCAL: w_rdy = w_cnt_zero && !r_pre;
      S_TRCAL: w_rdy = w_cnt_zero;
      S_DATA:  w_rdy = w_cnt_zero && !r_last;
      S_WAIT:  w_rdy = 1'b1;
      default: w_rdy = 1'b0;
    endcase
  end

  assign in_rdy = w_rdy;

  // Next-state, counter and pulse decode
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    w_state_nx    = r_state;
    w_cnt_nx      = w_cnt_zero ? r_cnt : (r_cnt - CNT_ONE);
    w_last_nx     = r_last;
    w_load_cfg    = 1'b0;
    w_cfg_err_nx  = 1'b0;
    w_underrun_nx = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (in_valid) begin
          if (w_cfg_ok) begin
            w_load_cfg = 1'b1;
            w_state_nx = S_DELIM;
            w_cnt_nx   = cfg_delim - CNT_ONE;
          end else begin
            w_cfg_err_nx = 1'b1;
          end
        end
      end
      S_DELIM: begin
        if (w_cnt_zero) begin
          w_state_nx = S_DATA0;
          w_cnt_nx   = r_zero - CNT_ONE;
        end
      end
      S_DATA0: begin
        if (w_cnt_zero) begin
          w_state_nx = S_RTCAL;
          w_cnt_nx   = r_rtcal - CNT_ONE;
        end
      end
      S_RTCAL: begin
        if (w_cnt_zero && r_pre) begin
          w_state_nx = S_TRCAL;
          w_cnt_nx   = r_trcal - CNT_ONE;
        end
      end
      S_DATA: begin
        if (w_cnt_zero && r_last) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end
      end
      default: begin
      end
    endcase

    // Bit hand-off: shared by preamble end, data symbol end and WAIT
    if (w_rdy) begin
      if (in_valid) begin
        w_state_nx = S_DATA;
        w_cnt_nx   = w_bit_cnt;
        w_last_nx  = in_last;
      end else if (r_state != S_WAIT) begin
        w_underrun_nx = 1'b1;
        w_cnt_nx      = '0;
`ifdef PIE_UNDERRUN_ABORT_EN
        w_state_nx    = S_IDLE;
`else
        w_state_nx    = S_WAIT;
`endif
      end
    end
  end

  // Waveform level for the cycle being entered
  assign w_pw_nx = w_load_cfg ? cfg_pw : r_pw;

  always_comb begin
    case (w_state_nx)
      S_IDLE:  w_out_pie_nx = 1'b1;
      S_WAIT:  w_out_pie_nx = 1'b1;
      S_DELIM: w_out_pie_nx = 1'b0;
      default: w_out_pie_nx = (w_cnt_nx >= w_pw_nx);
    endcase
  end

  // State register and registered outputs, synchronous reset aborts at once
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_out_pie  <= 1'b1;
      r_busy     <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_out_pie  <= w_out_pie_nx;
      r_busy     <= (w_state_nx != S_IDLE);
      r_cfg_err  <= w_cfg_err_nx;
      r_underrun <= w_underrun_nx;
    end
  end

  // Shadow timing and last flag, captured before any state reads them
  always_ff @(posedge clk) begin
    // NOTE: these are loaded before first use each frame, so they carry no reset.
    if (w_load_cfg) begin
      r_pw    <= cfg_pw;
      r_zero  <= cfg_zero;
      r_one   <= cfg_one;
      r_rtcal <= cfg_rtcal;
      r_trcal <= cfg_trcal;
      r_pre   <= cfg_preamble;
    end
    r_last <= w_last_nx;
  end

  assign out_pie  = r_out_pie;
  assign busy     = r_busy;
  assign cfg_err  = r_cfg_err;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_pie_frame_encoder.sv
// Directed bench for pie_frame_encoder: frame waveforms compared as
// run-length lists against hand-derived segment lengths.
module tb_pie_frame_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cfg_pw, cfg_zero, cfg_one, cfg_delim, cfg_rtcal, cfg_trcal;
  logic       cfg_preamble;
  logic       in_valid, in_rdy, in_bit, in_last;
  logic       out_pie, busy, cfg_err, underrun;

  int n_checks = 0;
  int n_errors = 0;

  logic bits [0:15];
  logic obs_q [$];
  int   runs_q [$];
  int   exp_q [$];
  int   hs_cnt;
  int   ur_cnt;

  pie_frame_encoder #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_pw(cfg_pw), .cfg_zero(cfg_zero), .cfg_one(cfg_one),
    .cfg_delim(cfg_delim), .cfg_rtcal(cfg_rtcal), .cfg_trcal(cfg_trcal),
    .cfg_preamble(cfg_preamble),
    .in_valid(in_valid), .in_rdy(in_rdy), .in_bit(in_bit), .in_last(in_last),
    .out_pie(out_pie), .busy(busy), .cfg_err(cfg_err), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_default_cfg();
    cfg_pw = 8'd3; cfg_zero = 8'd6; cfg_one = 8'd10; cfg_delim = 8'd3;
    cfg_rtcal = 8'd16; cfg_trcal = 8'd32; cfg_preamble = 1'b1;
  endtask

  // Drive a frame of n bits from bits[], record out_pie while busy.
  task automatic run_frame(input int n, input bit do_drop, input bit do_scramble);
    int  idx = 0;
    int  drop_left = 0;
    int  guard = 0;
    bit  hs;
    bit  started = 0;
    bit  done = 0;
    obs_q.delete();
    hs_cnt = 0;
    ur_cnt = 0;
    in_bit = bits[0];
    in_last = (n == 1);
    in_valid = 1'b1;
    while (!done && guard < 2000) begin
      @(negedge clk);
      if (underrun) ur_cnt++;
      if (busy) begin
        obs_q.push_back(out_pie);
        started = 1;
      end else if (started) begin
        done = 1;
      end
      if (!done) begin
        hs = in_valid && in_rdy;
        @(posedge clk);
        #1;
        if (hs) begin
          idx++;
          hs_cnt++;
          if (do_drop && idx == 1) drop_left = 20;
        end
        if (do_scramble && started) begin
          cfg_one = 8'd12; cfg_pw = 8'd1; cfg_preamble = 1'b0;
        end
        in_valid = (drop_left == 0) && (idx < n);
        if (drop_left > 0) drop_left--;
        if (idx < n) begin
          in_bit = bits[idx];
          in_last = (idx == n - 1);
        end
        guard++;
      end
    end
    in_valid = 1'b0;
    if (!done) check("frame_timeout", 0, 1);
    set_default_cfg();
  endtask

  // Compare the recorded waveform (starting low) against exp_q run lengths.
  task automatic compare_runs(input string tag);
    logic cur;
    int   len;
    runs_q.delete();
    if (obs_q.size() > 0) begin
      cur = obs_q[0];
      len = 0;
      foreach (obs_q[i]) begin
        if (obs_q[i] == cur) len++;
        else begin
          runs_q.push_back(len);
          cur = obs_q[i];
          len = 1;
        end
      end
      runs_q.push_back(len);
      check({tag, "_first_low"}, obs_q[0], 0);
    end
    check({tag, "_nruns"}, runs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < runs_q.size(); i++)
      check($sformatf("%s_run%0d", tag, i), runs_q[i], exp_q[i]);
  endtask

  initial begin
    set_default_cfg();
    in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_pie", out_pie, 1);
    check("rst_busy", busy, 0);
    check("rst_in_rdy", in_rdy, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_underrun", underrun, 0);

    // Preamble frame, bits 1,0,1
    bits[0] = 1; bits[1] = 0; bits[2] = 1;
    run_frame(3, 0, 0);
    exp_q = '{3,3,3,13,3,29,3,7,3,3,3,7,3};
    compare_runs("pre101");
    check("pre101_len", obs_q.size(), 83);
    check("pre101_hs", hs_cnt, 3);
    check("pre101_idle_cw", out_pie, 1);

    // Frame-sync frame, same bits: no TRcal
    cfg_preamble = 1'b0;
    run_frame(3, 0, 0);
    exp_q = '{3,3,3,13,3,7,3,3,3,7,3};
    compare_runs("fs101");
    check("fs101_len", obs_q.size(), 51);

    // Eight bits 1,1,0,0,1,0,1,0 with cfg changed mid-frame (must be ignored)
    bits[0] = 1; bits[1] = 1; bits[2] = 0; bits[3] = 0;
    bits[4] = 1; bits[5] = 0; bits[6] = 1; bits[7] = 0;
    run_frame(8, 0, 1);
    exp_q = '{3,3,3,13,3,29,3, 7,3,7,3,3,3,3,3,7,3,3,3,7,3,3,3};
    compare_runs("byte");
    check("byte_len", obs_q.size(), 121);
    check("byte_hs", hs_cnt, 8);

    // Underrun: valid dropped for 20 cycles after the first bit
    bits[0] = 1; bits[1] = 0; bits[2] = 1;
    run_frame(3, 1, 0);
    check("ur_pulses", ur_cnt, 1);
`ifdef PIE_UNDERRUN_ABORT_EN
    exp_q = '{3,3,3,13,3,29,3,7,3};
    compare_runs("ur_abort");
    check("ur_abort_hs", hs_cnt, 1);
    check("ur_abort_cw", out_pie, 1);
`else
    exp_q = '{3,3,3,13,3,29,3,7,3,14,3,7,3};
    compare_runs("ur_wait");
    check("ur_wait_hs", hs_cnt, 3);
`endif
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Inconsistent timing: PW == ZERO
    cfg_pw = 8'd6;
    in_bit = 1'b1; in_last = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b1;
    @(negedge clk);
    check("cerr_no_rdy", in_rdy, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("cerr_pulse", cfg_err, 1);
    check("cerr_busy", busy, 0);
    check("cerr_cw", out_pie, 1);
    @(negedge clk);
    check("cerr_pulse_end", cfg_err, 0);
    check("cerr_still_idle", busy, 0);
    set_default_cfg();

    // Reset during TRcal, then a clean frame
    in_bit = 1'b1; in_last = 1'b1;
    #1 in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_trcal", busy, 1);
    @(posedge clk);
    #1;
    check("midrst_cw", out_pie, 1);
    check("midrst_busy", busy, 0);
    check("midrst_rdy", in_rdy, 0);
    rst_n = 1'b1;
    bits[0] = 1; bits[1] = 0; bits[2] = 1;
    run_frame(3, 0, 0);
    exp_q = '{3,3,3,13,3,29,3,7,3,3,3,7,3};
    compare_runs("after_rst");
    check("after_rst_len", obs_q.size(), 83);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
